// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared ALU function codes, condition codes and CC bit layout
package y86_alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_LE = 4'd1;
  localparam logic [3:0] COND_L = 4'd2;
  localparam logic [3:0] COND_E = 4'd3;
  localparam logic [3:0] COND_NE = 4'd4;
  localparam logic [3:0] COND_GE = 4'd5;
  localparam logic [3:0] COND_G = 4'd6;
  localparam int ZF_BIT = 2;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 0;
  localparam logic [2:0] CC_RESET = 3'b100;
  typedef enum logic {EMPTY, FULL} occ_e;
endpackage

// File: rtl/y86_cond_eval.sv
// y86_cond_eval: evaluates a jXX/cmovXX condition against a CC value
module y86_cond_eval
  import y86_alu_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] cond_fn,
  output logic       cnd,
  output logic       bad_cond
);
  logic zf, x;
  assign zf = cc[ZF_BIT];
  assign x = cc[SF_BIT] ^ cc[OF_BIT];
  // condition table; unknown codes evaluate false and raise bad_cond
  always_comb begin
    bad_cond = cond_fn > COND_G;
    cnd = cond_fn == COND_ALWAYS ? 1'b1 :
          cond_fn == COND_LE     ? x | zf :
          cond_fn == COND_L      ? x :
          cond_fn == COND_E      ? zf :
          cond_fn == COND_NE     ? !zf :
          cond_fn == COND_GE     ? !x :
          cond_fn == COND_G      ? !x && !zf : 1'b0;
  end
endmodule

// File: rtl/y86_alu_cc.sv
// y86_alu_cc: Y-86 execute ALU with condition-code register and registered handshake output
module y86_alu_cc
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             set_cc,
  input  logic [3:0]       cond_fn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             cnd,
  output logic             bad_cond,
  output logic [2:0]       cc_out
);
  localparam int MSB = WIDTH - 1;
  occ_e state;
  logic [WIDTH-1:0] r;
  logic of, accept, c, bad;
  logic [2:0] cc, nf;
  assign out_valid = state == FULL;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign cc_out = cc;
  // result and the flags it would produce; carry-out is intentionally dropped
  always_comb begin
    r = alu_fun == ALU_ADD ? alu_b + alu_a :
        alu_fun == ALU_SUB ? alu_b - alu_a :
        alu_fun == ALU_AND ? alu_b & alu_a : alu_b ^ alu_a;
    of = alu_fun == ALU_ADD ? (alu_a[MSB] == alu_b[MSB]) && (r[MSB] != alu_a[MSB]) :
         alu_fun == ALU_SUB ? (alu_a[MSB] != alu_b[MSB]) && (r[MSB] != alu_b[MSB]) : 1'b0;
    nf = '0;
    nf[ZF_BIT] = r == '0;
    nf[SF_BIT] = r[MSB];
    nf[OF_BIT] = of;
  end
  y86_cond_eval u_cond (
    .cc(cc),
    .cond_fn(cond_fn),
    .cnd(c),
    .bad_cond(bad)
  );
  // condition sees CC before this op's update; occupancy bit tracks EMPTY/FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      val_e <= '0;
      cnd <= 1'b0;
      bad_cond <= 1'b0;
      cc <= CC_RESET;
    end else begin
      if (accept) begin
        val_e <= r;
        cnd <= c;
        bad_cond <= bad;
        if (set_cc) cc <= nf;
      end
      state <= accept ? FULL : out_ready ? EMPTY : state;
    end
  end
endmodule

// File: tb/tb_y86_alu_cc.sv
// tb_y86_alu_cc: directed and randomized checks of y86_alu_cc against a reference model
module tb_y86_alu_cc;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic iv = 0, ir, set = 0, ov, ordy = 1, cn, bd;
  logic [1:0] fun = 0;
  logic [3:0] a = 0, b = 0, ve, cf = 0;
  logic [2:0] cc;
  logic wiv = 0, wir, wset = 0, wov, wcn, wbd;
  logic [1:0] wfun = 0;
  logic [63:0] wa = 0, wb = 0, wve;
  logic [3:0] wcf = 0;
  logic [2:0] wcc;
  int n_cmp = 0, n_err = 0;

  y86_alu_cc #(.WIDTH(4)) d4 (.clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
    .alu_fun(fun), .alu_a(a), .alu_b(b), .set_cc(set), .cond_fn(cf), .out_valid(ov),
    .out_ready(ordy), .val_e(ve), .cnd(cn), .bad_cond(bd), .cc_out(cc));
  y86_alu_cc d64 (.clk(clk), .rst(rst), .in_valid(wiv), .in_ready(wir),
    .alu_fun(wfun), .alu_a(wa), .alu_b(wb), .set_cc(wset), .cond_fn(wcf), .out_valid(wov),
    .out_ready(1'b1), .val_e(wve), .cnd(wcn), .bad_cond(wbd), .cc_out(wcc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int f, input int aa, input int bb, input int s, input int c);
    iv = 1; fun = 2'(f); a = 4'(aa); b = 4'(bb); set = 1'(s); cf = 4'(c);
  endtask

  // signed-integer view of the four ops on 4-bit operands
  function automatic void ref_alu(input int f, input int aa, input int bb, output int r, output logic [2:0] fl);
    int sa, sb, ex;
    logic o;
    sa = aa > 7 ? aa - 16 : aa;
    sb = bb > 7 ? bb - 16 : bb;
    o = 0;
    case (f)
      0: begin ex = sb + sa; r = (bb + aa) % 16; o = ex > 7 || ex < -8; end
      1: begin ex = sb - sa; r = (bb - aa + 16) % 16; o = ex > 7 || ex < -8; end
      2: r = aa & bb;
      default: r = aa ^ bb;
    endcase
    fl = {r == 0, r >= 8, o};
  endfunction

  function automatic void ref_cond(input logic [2:0] c, input int sel, output logic y, output logic bad);
    logic less;
    less = c[1] != c[0];
    bad = sel > 6;
    case (sel)
      0: y = 1;
      1: y = less || c[2];
      2: y = less;
      3: y = c[2];
      4: y = !c[2];
      5: y = !less;
      6: y = !less && !c[2];
      default: y = 0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1; iv = 0; step(); step(); rst = 0; step();
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ov); end
    n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", ir); end
    n_cmp++; if (cc !== 3'b100) begin n_err++; $display("FAIL reset_cc got %b want 100", cc); end
    n_cmp++; if (ve !== 4'h0) begin n_err++; $display("FAIL reset_val_e got %h want 0", ve); end
    n_cmp++; if (wcc !== 3'b100) begin n_err++; $display("FAIL reset_cc64 got %b want 100", wcc); end
  endtask

  task automatic test_add();
    drive(0, 1, 14, 1, 0); step();
    n_cmp++; if (ve !== 4'b1111) begin n_err++; $display("FAIL add1_val got %b want 1111", ve); end
    n_cmp++; if (cc !== 3'b010) begin n_err++; $display("FAIL add1_cc got %b want 010", cc); end
    n_cmp++; if (ov !== 1'b1 || cn !== 1'b1) begin n_err++; $display("FAIL add1_valid_cnd got %b%b want 11", ov, cn); end
    drive(0, 1, 7, 1, 0); step();
    n_cmp++; if (ve !== 4'b1000) begin n_err++; $display("FAIL add2_val got %b want 1000", ve); end
    n_cmp++; if (cc !== 3'b011) begin n_err++; $display("FAIL add2_cc got %b want 011", cc); end
  endtask

  task automatic test_sub_cond();
    drive(1, 3, 2, 1, 0); step();
    n_cmp++; if (ve !== 4'b1111) begin n_err++; $display("FAIL sub_val got %b want 1111", ve); end
    n_cmp++; if (cc !== 3'b010) begin n_err++; $display("FAIL sub_cc got %b want 010", cc); end
    drive(2, 10, 3, 0, 2); step();
    n_cmp++; if (cn !== 1'b1) begin n_err++; $display("FAIL cond_l got %b want 1", cn); end
    n_cmp++; if (ve !== 4'b0010) begin n_err++; $display("FAIL and_val got %b want 0010", ve); end
    n_cmp++; if (cc !== 3'b010) begin n_err++; $display("FAIL and_cc_held got %b want 010", cc); end
    drive(2, 10, 3, 0, 5); step();
    n_cmp++; if (cn !== 1'b0) begin n_err++; $display("FAIL cond_ge got %b want 0", cn); end
  endtask

  task automatic test_xor();
    drive(3, 15, 15, 1, 0); step();
    n_cmp++; if (ve !== 4'b0000) begin n_err++; $display("FAIL xor_val got %b want 0000", ve); end
    n_cmp++; if (cc !== 3'b100) begin n_err++; $display("FAIL xor_cc got %b want 100", cc); end
  endtask

  task automatic test_back_to_back();
    int exp_v[3] = '{2, 5, 4};
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0);
      #1;
      n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, ir); end
      step();
      n_cmp++; if (ve !== 4'h0 || cc !== 3'b100 || ov !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got v=%h cc=%b ov=%b want v=0 cc=100 ov=1", i, ve, cc, ov); end
    end
    ordy = 1;
    drive(0, 1, 1, 1, 0); step();
    n_cmp++; if (ve !== 4'(exp_v[0]) || ov !== 1'b1) begin n_err++; $display("FAIL b2b0 got %h/%b want %h/1", ve, ov, exp_v[0]); end
    drive(0, 2, 3, 1, 0); step();
    n_cmp++; if (ve !== 4'(exp_v[1]) || ov !== 1'b1) begin n_err++; $display("FAIL b2b1 got %h/%b want %h/1", ve, ov, exp_v[1]); end
    drive(1, 1, 5, 1, 0); step();
    n_cmp++; if (ve !== 4'(exp_v[2]) || ov !== 1'b1) begin n_err++; $display("FAIL b2b2 got %h/%b want %h/1", ve, ov, exp_v[2]); end
    iv = 0; step();
    n_cmp++; if (ov !== 1'b0 || ve !== 4'(exp_v[2])) begin n_err++; $display("FAIL drain got ov=%b v=%h want ov=0 v=%h", ov, ve, exp_v[2]); end
  endtask

  task automatic test_bad_cond();
    drive(0, 1, 1, 1, 9); step();
    n_cmp++; if (cn !== 1'b0 || bd !== 1'b1) begin n_err++; $display("FAIL badcond got cnd=%b bad=%b want 0 1", cn, bd); end
    n_cmp++; if (ve !== 4'h2 || cc !== 3'b000) begin n_err++; $display("FAIL badcond_alu got v=%h cc=%b want 2 000", ve, cc); end
    iv = 0;
  endtask

  task automatic test_w64();
    wiv = 1; wfun = 0; wa = 64'd1; wb = 64'h7fff_ffff_ffff_ffff; wset = 1; wcf = 0;
    step(); wiv = 0;
    n_cmp++; if (wve !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL w64_val got %h want 8000000000000000", wve); end
    n_cmp++; if (wcc !== 3'b011 || wov !== 1'b1) begin n_err++; $display("FAIL w64_cc got %b ov=%b want 011 1", wcc, wov); end
  endtask

  task automatic test_random();
    logic mv = 0, mc = 0, mb = 0, er, y, bad;
    logic [2:0] mcc = 3'b100, fl;
    int mval = 0, r, f, aa, bb, s, c;
    rst = 1; iv = 0; step(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      f = $urandom_range(0, 3); aa = $urandom_range(0, 15); bb = $urandom_range(0, 15);
      s = $urandom_range(0, 1); c = $urandom_range(0, 9);
      drive(f, aa, bb, s, c);
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      #1;
      er = !mv || ordy;
      n_cmp++; if (ir !== er) begin n_err++; $display("FAIL rnd_in_ready[%0d] got %b want %b", i, ir, er); end
      if (iv && er) begin
        ref_alu(f, aa, bb, r, fl);
        ref_cond(mcc, c, y, bad);
        mval = r; mc = y; mb = bad; mv = 1;
        if (s != 0) mcc = fl;
      end else if (ordy) mv = 0;
      step();
      n_cmp++;
      if (ov !== mv || ve !== 4'(mval) || cn !== mc || bd !== mb || cc !== mcc) begin
        n_err++;
        $display("FAIL rnd_out[%0d] got ov=%b v=%h c=%b b=%b cc=%b want ov=%b v=%h c=%b b=%b cc=%b", i, ov, ve, cn, bd, cc, mv, 4'(mval), mc, mb, mcc);
      end
    end
    iv = 0; ordy = 1;
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 1, 7, 1, 0); ordy = 1; step();
    ordy = 0; step();
    n_cmp++; if (ov !== 1'b1 || cc !== 3'b011) begin n_err++; $display("FAIL prestall got ov=%b cc=%b want 1 011", ov, cc); end
    rst = 1; step(); rst = 0; iv = 0; ordy = 1;
    n_cmp++; if (ov !== 1'b0 || cc !== 3'b100 || ve !== 4'h0) begin n_err++; $display("FAIL rst_stall got ov=%b cc=%b v=%h want 0 100 0", ov, cc, ve); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cond();
    test_xor();
    test_back_to_back();
    test_bad_cond();
    test_w64();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/y86_alu_cc.md
Name: y86_alu_cc

Overview:
- Parametrised execute-stage ALU with an architectural condition-code (CC) register, for the Y-86 SEQ/PIPE datapath.
- Performs the four Y-86 OPq functions on WIDTH-bit operands and computes valE = B op A.
- Optionally updates ZF/SF/OF and evaluates the jXX/cmovXX condition `cnd` against the CC state current at acceptance.
- Result is registered behind a valid/ready handshake, so the block can be dropped into the pipelined core unchanged.

Parameters:
- WIDTH, 64: operand/result width in bits; must be >= 2.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: block can accept. Equals !out_valid || out_ready.
- alu_fun, input, 2: 00 add, 01 sub, 10 and, 11 xor.
- alu_a, input, WIDTH: operand A (aluA).
- alu_b, input, WIDTH: operand B (aluB).
- set_cc, input, 1: update CC from this operation.
- cond_fn, input, 4: condition select. 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
- out_valid, output, 1: result register holds a valid result.
- out_ready, input, 1: consumer takes result.
- val_e, output, WIDTH: registered result.
- cnd, output, 1: registered condition outcome.
- bad_cond, output, 1: registered; cond_fn was 7..15.
- cc_out, output, 3: live CC register. [2]=ZF, [1]=SF, [0]=OF.

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high, sampled on the rising edge.
- Reset values: out_valid=0, val_e=0, cnd=0, bad_cond=0, cc_out=3'b100 (ZF=1, SF=0, OF=0).
- Reset overrides any simultaneous accept. An in-flight result is discarded, not delivered.
- Accept: the operation is accepted on an edge where in_valid && in_ready. Latency is one cycle: on that edge val_e, cnd and bad_cond load and out_valid goes to 1.
- Drain: if out_valid && out_ready with no accept on the same edge, out_valid goes to 0. val_e, cnd and bad_cond hold their last values.
- Simultaneous drain and accept: the old result leaves and the new one loads on the same edge, giving full throughput with no bubble.
- Backpressure: while out_valid && !out_ready, in_ready=0. val_e, cnd and bad_cond stay stable, and CC is not updated.
- Arithmetic, modulo 2^WIDTH:
  - add: B+A.
  - sub: B−A.
  - and: B&A.
  - xor: B^A.
  - Carry-out is not architecturally visible.
- Flags from result r:
  - ZF = (r==0).
  - SF = r[WIDTH-1].
  - add OF = (A[msb]==B[msb]) && (r[msb]!=A[msb]).
  - sub OF = (A[msb]!=B[msb]) && (r[msb]!=B[msb]).
  - and/xor OF = 0.
- CC update: the CC register loads new flags only on an accept edge with set_cc=1. Otherwise it is held.
- cnd evaluation: cnd uses the CC value before this operation's own update (Y-86 semantics). Back-to-back ops therefore see the predecessor's update. With X = SF^OF:
  - always: 1.
  - le: X|ZF.
  - l: X.
  - e: ZF.
  - ne: !ZF.
  - ge: !X.
  - g: !X&&!ZF.
- Invalid condition: cond_fn 7..15 gives cnd=0 and bad_cond=1. The ALU result and CC update still happen.
- Idle inputs are ignored: when in_valid=0, alu_fun, alu_a, alu_b, set_cc and cond_fn are don't-care and no state changes.
- No internal FSM beyond the out_valid full/empty bit. States are EMPTY and FULL:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept, or on stall.

Decomposition:
- Package y86_alu_pkg holds:
  - ALU_ADD/SUB/AND/XOR codes.
  - COND_ALWAYS..COND_G codes.
  - CC bit indices ZF_BIT/SF_BIT/OF_BIT.
  - CC_RESET = 3'b100.
- Sub-module y86_cond_eval is combinational: (cc, cond_fn) → (cnd, bad_cond). It is reused by the cmov/jump logic.
- The ALU datapath, flag computation and handshake register stay in the top level.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, cc_out=100, val_e=0. Assert rst mid-stall with out_valid=1 → next edge out_valid=0, cc_out=100.
- WIDTH=4, add A=0001 B=1110 set_cc=1 → val_e=1111, cc=010. Then add A=0001 B=0111 → val_e=1000, cc=011 (OF).
- WIDTH=4, sub A=0011 B=0010 set_cc=1 → val_e=1111, cc=010. The next op with cond_fn=2 (l) gives cnd=1; cond_fn=5 (ge) gives cnd=0.
- and A=1010 B=0011 set_cc=0 after a cc=010 state → val_e=0010, cc_out stays 010. xor A=1111 B=1111 set_cc=1 → val_e=0000, cc=100.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and new operands → in_ready=0, val_e unchanged, cc unchanged. Release → one result per cycle with no bubble.
- cond_fn=9 with add A=1 B=1 set_cc=1 → cnd=0, bad_cond=1, val_e=2, cc=000. Default WIDTH=64: add A=1 B=2^63−1 → val_e=2^63, SF=1, OF=1.
